// File: rtl/servant_bus_pkg.sv
// Shared definitions for the servant bus fabric: arbiter state encodings,
// the default read-data pattern for timed-out transfers, and a helper that
// sizes the bus watchdog counter.
package servant_bus_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;

  localparam logic [31:0] ARB_ERR_RDT_DEFAULT = 32'hDEAD_BEEF;

  // Width of a counter that must reach timeout-1; kept at least one bit so
  // a disabled watchdog (timeout == 0) still yields a legal vector.
  function automatic int arb_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/servant_wb_arbiter.sv
// Two-master Wishbone arbiter in front of servant_mux. Round-robin per
// transfer, grant held until the slave acks, the master aborts, or the bus
// watchdog expires and terminates the transfer with an error read pattern.
module servant_wb_arbiter
  import servant_bus_pkg::*;
#(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERR_RDT = ARB_ERR_RDT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // CPU data bus master
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_cyc,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  // Second master (DMA / accelerator)
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_cyc,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  // Towards the mux master port
  output logic [31:0] o_wb_s_adr,
  output logic [31:0] o_wb_s_dat,
  output logic [3:0]  o_wb_s_sel,
  output logic        o_wb_s_we,
  output logic        o_wb_s_cyc,
  input  logic [31:0] i_wb_s_rdt,
  input  logic        i_wb_s_ack,
  // Watchdog reporting
  output logic        o_timeout,
  output logic        o_timeout_master
);

  localparam int                 CNT_W    = arb_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic               WDOG_EN  = (TIMEOUT > 0);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             tmaster_q, tmaster_d;

  logic gnt0, gnt1, gnt_any, m_cyc, expire;

  // Decode the grant, pick the granted master's cyc and detect watchdog expiry.
  // A real ack in the expiry cycle takes precedence, so expiry excludes it.
  always_comb begin
    gnt0    = (state_q == ARB_GNT0);
    gnt1    = (state_q == ARB_GNT1);
    gnt_any = gnt0 | gnt1;
    m_cyc   = gnt1 ? i_wb_m1_cyc : i_wb_m0_cyc;
    expire  = WDOG_EN & gnt_any & m_cyc & (cnt_q == CNT_LAST) & ~i_wb_s_ack;
  end

  // Route the granted master to the slave port and the slave response back.
  // Outside a grant the payload follows m0 but cyc is low, so it is ignored.
  always_comb begin
    o_wb_s_adr  = gnt1 ? i_wb_m1_adr : i_wb_m0_adr;
    o_wb_s_dat  = gnt1 ? i_wb_m1_dat : i_wb_m0_dat;
    o_wb_s_sel  = gnt1 ? i_wb_m1_sel : i_wb_m0_sel;
    o_wb_s_we   = gnt1 ? i_wb_m1_we  : i_wb_m0_we;
    o_wb_s_cyc  = gnt_any & m_cyc & ~expire;
    o_wb_m0_ack = gnt0 & (i_wb_s_ack | expire);
    o_wb_m1_ack = gnt1 & (i_wb_s_ack | expire);
    o_wb_m0_rdt = gnt0 ? (expire ? ERR_RDT : i_wb_s_rdt) : 32'h0;
    o_wb_m1_rdt = gnt1 ? (expire ? ERR_RDT : i_wb_s_rdt) : 32'h0;
    o_timeout        = timeout_q;
    o_timeout_master = tmaster_q;
  end

  // Arbitration FSM and watchdog counter next-state logic. The counter is
  // cleared while idle so it starts at zero on the first cycle of a grant.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = expire;
    tmaster_d = expire ? gnt1 : tmaster_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (i_wb_m0_cyc && i_wb_m1_cyc) begin
          if (last_q) begin
            state_d = ARB_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = ARB_GNT1;
            last_d  = 1'b1;
          end
        end else if (i_wb_m0_cyc) begin
          state_d = ARB_GNT0;
          last_d  = 1'b0;
        end else if (i_wb_m1_cyc) begin
          state_d = ARB_GNT1;
          last_d  = 1'b1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (i_wb_s_ack || !m_cyc || expire) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; asynchronous reset drops every output immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      tmaster_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      tmaster_q <= tmaster_d;
    end
  end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Bench for servant_wb_arbiter: directed latency/boundary sequences followed
// by randomized traffic from both masters against a delay-programmable slave,
// with a scoreboard monitor checking every master response.
module tb_servant_wb_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_dat, s_rdt;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_ack;
  logic        tmo, tmo_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servant_wb_arbiter #(.TIMEOUT(TO), .ERR_RDT(ERR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
    .i_wb_m0_we(m0_we), .i_wb_m0_cyc(m0_cyc),
    .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack),
    .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
    .i_wb_m1_we(m1_we), .i_wb_m1_cyc(m1_cyc),
    .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack),
    .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
    .o_wb_s_we(s_we), .o_wb_s_cyc(s_cyc),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack),
    .o_timeout(tmo), .o_timeout_master(tmo_m)
  );

  // Slave model: address bits [7:4] give the number of cycles of cyc before
  // ack (0 = same cycle). Ack is gated by the masters' cyc lines rather than
  // the arbiter's cyc output so the bench adds no combinational loop.
  logic [3:0] scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              scnt <= 4'd0;
    else if (s_cyc && !s_ack) scnt <= scnt + 4'd1;
    else                     scnt <= 4'd0;
  end
  assign s_ack = (m0_cyc | m1_cyc) && (scnt == s_adr[7:4]);
  assign s_rdt = s_cyc ? ~s_adr : 32'h0BAD_0BAD;

  typedef struct {
    logic [31:0] rdt;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        to;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic mon_en = 1'b0;
  logic to_pend = 1'b0;
  logic to_m = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_adr = 32'h0; m0_dat = 32'h0; m0_sel = 4'h0; m0_we = 1'b0; m0_cyc = 1'b0;
    m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'h0; m1_we = 1'b0; m1_cyc = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Pop the oldest expected response for master m and compare.
  task automatic pop_check(input int m, input logic [31:0] rdt);
    exp_t e;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_ack: master %0d acked with no transfer outstanding", m);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("rdt_m%0d", m), rdt, e.rdt);
    if (e.to) begin
      to_pend = 1'b1;
      to_m    = (m == 1);
      check("slave_cyc_in_timeout", 32'(s_cyc), 32'd0);
    end else begin
      check("slave_adr", s_adr, e.adr);
      check("slave_dat", s_dat, e.dat);
      check("slave_sel", 32'(s_sel), 32'(e.sel));
      check("slave_we",  32'(s_we),  32'(e.we));
    end
  endtask

  // Scoreboard monitor: compares every master ack against the queued
  // expectation and the timeout pulse one cycle after a watchdog ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (to_pend) begin
        check("timeout_pulse", 32'(tmo), 32'd1);
        check("timeout_master", 32'(tmo_m), 32'(to_m));
      end else begin
        check("timeout_quiet", 32'(tmo), 32'd0);
      end
      to_pend = 1'b0;
      check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
      if (m0_ack) pop_check(0, m0_rdt);
      if (m1_ack) pop_check(1, m1_rdt);
    end
  end

  // Random master: issues n transfers, holding cyc until its ack.
  task automatic drive_m(input int m, input int n);
    logic [3:0]  dtab [7];
    logic [31:0] a;
    logic [3:0]  d;
    exp_t        e;
    logic        got;
    int          gap;
    dtab[0] = 4'd0; dtab[1] = 4'd1; dtab[2] = 4'd2; dtab[3] = 4'd3;
    dtab[4] = 4'd7; dtab[5] = 4'd8; dtab[6] = 4'd15;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        if (m == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
        repeat (gap) tick();
      end
      d = dtab[$urandom_range(0, 6)];
      a = $urandom;
      a[7:4] = d;
      e.adr = a;
      e.dat = $urandom;
      e.sel = 4'($urandom_range(1, 15));
      e.we  = 1'($urandom_range(0, 1));
      e.to  = (int'(d) >= TO);
      e.rdt = e.to ? ERR : ~a;
      if (m == 0) begin
        m0_adr = e.adr; m0_dat = e.dat; m0_sel = e.sel; m0_we = e.we; m0_cyc = 1'b1;
        q0.push_back(e);
      end else begin
        m1_adr = e.adr; m1_dat = e.dat; m1_sel = e.sel; m1_we = e.we; m1_cyc = 1'b1;
        q1.push_back(e);
      end
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if ((m == 0) ? m0_ack : m1_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_wait_m%0d: no ack within 40 cycles for adr %h", m, a);
      end
      tick();
    end
    if (m == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int ord[$];
    int who;
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_cyc",  32'(s_cyc),  32'd0);
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_m1_ack", 32'(m1_ack), 32'd0);
    check("rst_m0_rdt", m0_rdt, 32'd0);
    check("rst_m1_rdt", m1_rdt, 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);
    check("rst_tmaster", 32'(tmo_m), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single m0 read with a one-cycle slave: cyc at N+1, ack at N+2.
    m0_adr = 32'h0000_0010; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b1;
    @(negedge clk);
    check("rd_cyc_N", 32'(s_cyc), 32'd0);
    tick(); @(negedge clk);
    check("rd_cyc_N1", 32'(s_cyc), 32'd1);
    check("rd_ack_N1", 32'(m0_ack), 32'd0);
    tick(); @(negedge clk);
    check("rd_ack_N2", 32'(m0_ack), 32'd1);
    check("rd_rdt_N2", m0_rdt, ~32'h0000_0010);
    check("rd_m1_ack", 32'(m1_ack), 32'd0);
    tick();
    m0_cyc = 1'b0;
    tick();

    // Tie right after reset, both masters requesting continuously.
    reset_pulse();
    m0_adr = 32'h0000_1010; m0_sel = 4'hF; m0_cyc = 1'b1;
    m1_adr = 32'h0001_0010; m1_sel = 4'hF; m1_cyc = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m0_ack) ord.push_back(0);
      if (m1_ack) ord.push_back(1);
      if (ord.size() >= 4) break;
      tick();
    end
    check("tie_count", 32'(ord.size()), 32'd4);
    for (int i = 0; i < ord.size(); i++)
      check($sformatf("tie_order_%0d", i), 32'(ord[i]), 32'(i % 2));
    tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();

    // m1 write to a slave that never acks: watchdog fires at count TO-1.
    m1_adr = 32'h0000_20F0; m1_dat = 32'h1234_5678; m1_sel = 4'hF; m1_we = 1'b1; m1_cyc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) m1_cyc = 1'b0;
      @(negedge clk);
      if (i < TO) check($sformatf("to_noack_%0d", i), 32'(m1_ack), 32'd0);
      if (i == TO - 1) check("to_cyc_before", 32'(s_cyc), 32'd1);
      if (i == TO) begin
        check("to_ack", 32'(m1_ack), 32'd1);
        check("to_rdt", m1_rdt, ERR);
        check("to_cyc_low", 32'(s_cyc), 32'd0);
        check("to_m0_ack", 32'(m0_ack), 32'd0);
      end
      if (i == TO + 1) begin
        check("to_pulse", 32'(tmo), 32'd1);
        check("to_master", 32'(tmo_m), 32'd1);
      end
      if (i == TO + 2) begin
        check("to_pulse_end", 32'(tmo), 32'd0);
        check("to_master_sticky", 32'(tmo_m), 32'd1);
      end
    end
    m1_we = 1'b0;

    // Slave acks exactly at count TO-1: normal ack, no timeout.
    m0_adr = 32'h0000_3070; m0_we = 1'b0; m0_cyc = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 9) m0_cyc = 1'b0;
      @(negedge clk);
      if (i == TO - 1) check("edge_noack", 32'(m0_ack), 32'd0);
      if (i == TO) begin
        check("edge_ack", 32'(m0_ack), 32'd1);
        check("edge_rdt", m0_rdt, ~32'h0000_3070);
      end
      if (i == TO + 1) check("edge_no_timeout", 32'(tmo), 32'd0);
    end
    tick();

    // m0 aborts during its grant; pending m1 granted after one idle cycle.
    m0_adr = 32'h0000_40F0; m0_cyc = 1'b1;
    tick();
    m1_adr = 32'h0000_5010; m1_we = 1'b0; m1_cyc = 1'b1;
    @(negedge clk);
    check("ab_gnt0_cyc", 32'(s_cyc), 32'd1);
    check("ab_gnt0_adr", s_adr, 32'h0000_40F0);
    tick();
    m0_cyc = 1'b0;
    @(negedge clk);
    check("ab_drop_cyc", 32'(s_cyc), 32'd0);
    check("ab_drop_ack", 32'(m0_ack), 32'd0);
    tick(); @(negedge clk);
    check("ab_idle_cyc", 32'(s_cyc), 32'd0);
    tick(); @(negedge clk);
    check("ab_gnt1_cyc", 32'(s_cyc), 32'd1);
    check("ab_gnt1_adr", s_adr, 32'h0000_5010);
    tick(); @(negedge clk);
    check("ab_m1_ack", 32'(m1_ack), 32'd1);
    check("ab_m1_rdt", m1_rdt, ~32'h0000_5010);
    tick();
    m1_cyc = 1'b0;
    tick();

    // Asynchronous reset while m1 holds the bus.
    m1_adr = 32'h0000_60F0; m1_cyc = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", 32'(s_cyc), 32'd0);
    check("arst_m1_ack", 32'(m1_ack), 32'd0);
    check("arst_m1_rdt", m1_rdt, 32'd0);
    check("arst_tmaster", 32'(tmo_m), 32'd0);
    m0_adr = 32'h0000_7010; m0_cyc = 1'b1;
    m1_adr = 32'h0000_8010;
    @(posedge clk); #1;
    rst_n = 1'b1;
    who = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0_ack) begin who = 0; break; end
      if (m1_ack) begin who = 1; break; end
      tick();
    end
    check("arst_first_tie", 32'(who), 32'd0);
    tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    repeat (2) tick();

    // Randomized traffic from both masters under the scoreboard.
    mon_en = 1'b1;
    fork
      drive_m(0, 40);
      drive_m(1, 40);
    join
    repeat (4) tick();
    mon_en = 1'b0;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
